ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader_if.sv | 25 ++
 rtl/ram_loader.sv | 100 ++++++++++
 tb/tb_ram_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_loader_if.sv
// Host byte handshake and shared-bus strobes between a program host and the loader.
interface ram_loader_if #(
  parameter int unsigned DATA_W = 8
);
  logic              host_valid;
  logic [DATA_W-1:0] host_data;
  logic              host_last;
  logic              host_ready;
  logic              bus_drive;
  logic [DATA_W-1:0] bus_out;
  logic              mar_read_from_bus;
  logic              ram_read_from_bus;

  // Host / bus-observer side
  modport master (
    output host_valid, host_data, host_last,
    input  host_ready, bus_drive, bus_out, mar_read_from_bus, ram_read_from_bus
  );

  // Loader side
  modport slave (
    input  host_valid, host_data, host_last,
    output host_ready, bus_drive, bus_out, mar_read_from_bus, ram_read_from_bus
  );
endinterface

// File: rtl/ram_loader.sv
// Loads a host-supplied program into RAM over the shared bus while holding the CPU.
// Each byte costs three cycles: host accept, MAR address strobe, RAM data strobe.
module ram_loader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  ram_loader_if.slave       bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    LOAD_MAR,
    LOAD_RAM,
    FINISH
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  // Every output is a register set for the state being entered, so nothing
  // from host_* reaches the bus combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      addr                  <= '0;
      data_q                <= '0;
      last_q                <= 1'b0;
      byte_count            <= '0;
      done                  <= 1'b0;
      error                 <= 1'b0;
      cpu_hold              <= 1'b0;
      busy                  <= 1'b0;
      bus.host_ready        <= 1'b0;
      bus.bus_drive         <= 1'b0;
      bus.bus_out           <= '0;
      bus.mar_read_from_bus <= 1'b0;
      bus.ram_read_from_bus <= 1'b0;
    end else if ((state == IDLE || state == FINISH) && start) begin
      state          <= WAIT_BYTE;
      addr           <= '0;
      byte_count     <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      cpu_hold       <= 1'b1;
      busy           <= 1'b1;
      bus.host_ready <= 1'b1;
    end else begin
      case (state)
        WAIT_BYTE: begin
          if (bus.host_valid) begin
            state                 <= LOAD_MAR;
            data_q                <= bus.host_data;
            last_q                <= bus.host_last;
            bus.host_ready        <= 1'b0;
            bus.bus_drive         <= 1'b1;
            bus.bus_out           <= DATA_W'(addr);
            bus.mar_read_from_bus <= 1'b1;
          end
        end
        LOAD_MAR: begin
          state                 <= LOAD_RAM;
          bus.bus_out           <= data_q;
          bus.mar_read_from_bus <= 1'b0;
          bus.ram_read_from_bus <= 1'b1;
        end
        LOAD_RAM: begin
          bus.bus_drive         <= 1'b0;
          bus.bus_out           <= '0;
          bus.ram_read_from_bus <= 1'b0;
          byte_count            <= byte_count + (ADDR_W + 1)'(1);
          if (last_q || addr == '1) begin
            // Top address written without host_last: stop rather than wrap.
            state    <= FINISH;
            error    <= ~last_q;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
          end else begin
            state          <= WAIT_BYTE;
            addr           <= addr + ADDR_W'(1);
            bus.host_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a scoreboard of expected MAR/RAM bus values.
module tb_ram_loader;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          cpu_hold, busy, done, error;
  logic [AW:0]   byte_count;

  ram_loader_if #(.DATA_W(DW)) bif ();

  ram_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bif.slave),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_mar_q[$];
  logic [DW-1:0] exp_ram_q[$];
  logic [DW-1:0] mem [16];
  logic [DW-1:0] mar_reg = '0;
  logic [DW-1:0] last_mar = '0;
  int            mar_cnt = 0;
  int            ram_cnt = 0;
  bit            mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus observer: models MAR + RAM and pops the scoreboard on each strobe.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!bif.bus_drive) chk("bus_idle_zero", 32'(bif.bus_out), 0);
      if (bif.mar_read_from_bus || bif.ram_read_from_bus) begin
        chk("strobe_exclusive", 32'(bif.mar_read_from_bus & bif.ram_read_from_bus), 0);
        chk("strobe_with_drive", 32'(bif.bus_drive), 1);
      end
      if (bif.mar_read_from_bus) begin
        if (exp_mar_q.size() == 0) chk("unexpected_mar", 32'(bif.bus_out), 32'hFFFF_FFFF);
        else chk("mar_bus", 32'(bif.bus_out), 32'(exp_mar_q.pop_front()));
        mar_reg  = bif.bus_out;
        last_mar = bif.bus_out;
        mar_cnt++;
      end
      if (bif.ram_read_from_bus) begin
        if (exp_ram_q.size() == 0) chk("unexpected_ram", 32'(bif.bus_out), 32'hFFFF_FFFF);
        else chk("ram_bus", 32'(bif.bus_out), 32'(exp_ram_q.pop_front()));
        mem[mar_reg[AW-1:0]] = bif.bus_out;
        ram_cnt++;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the LOAD_MAR cycle.
  task automatic send_byte(input logic [DW-1:0] d, input logic l, input logic [DW-1:0] a);
    int n = 0;
    bif.host_valid = 1'b1;
    bif.host_data  = d;
    bif.host_last  = l;
    while (!bif.host_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bif.host_ready) begin
      chk("ready_timeout", 32'(bif.host_ready), 1);
    end else begin
      exp_mar_q.push_back(a);
      exp_ram_q.push_back(d);
      @(posedge clk);
      @(negedge clk);
    end
    bif.host_valid = 1'b0;
    bif.host_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({bif.host_ready, bif.bus_drive, bif.mar_read_from_bus, bif.ram_read_from_bus,
                  cpu_hold, busy, done, error}), 0);
    chk(tag, 32'(bif.bus_out), 0);
    chk(tag, 32'(byte_count), 0);
  endtask

  initial begin
    int mar0, ram0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    bif.host_valid = 1'b0;
    bif.host_data  = '0;
    bif.host_last  = 1'b0;

    // Reset
    repeat (3) @(negedge clk);
    chk_all_zero("in_reset");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("after_reset");
    mon_en = 1'b1;

    // Three-byte program
    pulse_start();
    chk("busy_on_start", 32'({busy, cpu_hold, bif.host_ready}), 32'h7);
    send_byte(8'h11, 1'b0, 8'h00);
    send_byte(8'h22, 1'b0, 8'h01);
    send_byte(8'h33, 1'b1, 8'h02);
    wait_done();
    chk("p3_error", 32'(error), 0);
    chk("p3_count", 32'(byte_count), 3);
    chk("p3_idle_outs", 32'({busy, cpu_hold, bif.host_ready}), 0);
    chk("p3_mem", 32'({mem[0], mem[1], mem[2]}), 32'h112233);

    // Full 16-byte image with host_last on the final byte
    mar0 = mar_cnt;
    ram0 = ram_cnt;
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(8'(i), i == 15, 8'(i));
    wait_done();
    chk("p16_error", 32'(error), 0);
    chk("p16_count", 32'(byte_count), 16);
    chk("p16_mar_n", 32'(mar_cnt - mar0), 16);
    chk("p16_ram_n", 32'(ram_cnt - ram0), 16);
    chk("p16_last_mar", 32'(last_mar), 32'h0F);

    // 16 bytes, never marked last: overflow error
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i), 1'b0, 8'(i));
    wait_done();
    chk("ovf_error", 32'(error), 1);
    chk("ovf_count", 32'(byte_count), 16);
    bif.host_valid = 1'b1;
    bif.host_data  = 8'hEE;
    repeat (5) begin
      @(negedge clk);
      chk("ovf_no_ready", 32'(bif.host_ready), 0);
    end
    bif.host_valid = 1'b0;
    chk("ovf_mem15", 32'(mem[15]), 32'h8F);

    // Host stalls 20 cycles after start
    pulse_start();
    chk("stall_cleared", 32'({done, error}), 0);
    mar0 = mar_cnt;
    ram0 = ram_cnt;
    repeat (20) begin
      @(negedge clk);
      chk("stall_hold", 32'({cpu_hold, bif.host_ready}), 32'h3);
    end
    chk("stall_no_strobe", 32'((mar_cnt - mar0) + (ram_cnt - ram0)), 0);
    send_byte(8'hA5, 1'b1, 8'h00);
    wait_done();
    chk("stall_mem0", 32'(mem[0]), 32'hA5);

    // Reset during LOAD_MAR of the second byte
    pulse_start();
    send_byte(8'h55, 1'b0, 8'h00);
    bif.host_valid = 1'b1;
    bif.host_data  = 8'h66;
    for (int n = 0; n < 50 && !bif.host_ready; n++) @(negedge clk);
    chk("abort_ready", 32'(bif.host_ready), 1);
    exp_mar_q.push_back(8'h01);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bif.host_valid = 1'b0;
    @(negedge clk);
    ram0 = ram_cnt;
    @(negedge clk);
    chk_all_zero("abort_outs");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_ram", 32'(ram_cnt - ram0), 0);
    chk("abort_mem", 32'({mem[0], mem[1]}), 32'h5581);
    pulse_start();
    send_byte(8'h77, 1'b1, 8'h00);
    wait_done();
    chk("abort_restart", 32'({mem[0], 3'b000, byte_count}), 32'h7701);

    // start during a load is ignored; start in FINISH restarts
    pulse_start();
    send_byte(8'h31, 1'b0, 8'h00);
    pulse_start();
    chk("ign_busy", 32'(busy), 1);
    send_byte(8'h32, 1'b1, 8'h01);
    wait_done();
    chk("ign_count", 32'(byte_count), 2);
    pulse_start();
    chk("restart_state", 32'({done, error, bif.host_ready, busy}), 32'h3);
    chk("restart_count", 32'(byte_count), 0);
    send_byte(8'h41, 1'b1, 8'h00);
    wait_done();
    chk("restart_result", 32'({mem[0], mem[1], 3'b000, byte_count}), 32'h413201);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(exp_mar_q.size() + exp_ram_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
